// File: rtl/divide_tokens_if.sv
// Token-divider bus: shared ratio/clear controls plus per-channel token lanes.
// The master drives tokens and controls; the divider (slave) returns the surviving tokens.
interface divide_tokens_if #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 4
);
  logic                clear;
  logic [DIV_W-1:0]    div;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;

  modport master (output clear, output div, output a, input b);
  modport slave  (input clear, input div, input a, output b);
endinterface

// File: rtl/divide_tokens.sv
// Multi-channel token divider: each lane passes every div-th '1' token and drops the rest.
// The ratio is shared and sampled live; the output is combinational or registered.
module divide_tokens #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 4,
  parameter int REG_OUT  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  divide_tokens_if.slave  tok
);

  logic [DIV_W-1:0]    cnt_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_d [CHANNELS];
  logic [DIV_W-1:0]    div_eff;
  logic [DIV_W-1:0]    pass_lvl;
  logic [CHANNELS-1:0] pass;

  // A zero ratio behaves as pass-through.
  function automatic logic [DIV_W-1:0] eff_ratio(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  always_comb begin
    div_eff  = eff_ratio(tok.div);
    pass_lvl = div_eff - DIV_W'(1);
    pass     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      // ">=" lets a lowered ratio release the next token immediately.
      pass[i]  = tok.a[i] & ~tok.clear & (cnt_q[i] >= pass_lvl);
      if (tok.clear) begin
        cnt_d[i] = '0;
      end else if (pass[i]) begin
        cnt_d[i] = '0;
      end else if (tok.a[i]) begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [CHANNELS-1:0] b_q;
      logic [CHANNELS-1:0] b_d;

      always_comb begin
        b_d = pass;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q <= '0;
        end else begin
          b_q <= b_d;
        end
      end

      assign tok.b = b_q;
    end else begin : g_comb_out
      // Counters sit at zero during reset, so a unit ratio would otherwise leak a onto b.
      assign tok.b = pass & {CHANNELS{rst_n}};
    end
  endgenerate

endmodule

// File: tb/tb_divide_tokens.sv
// Bench for divide_tokens: combinational and registered instances driven in lockstep,
// checked against a token-count reference model plus literal sequences.
module tb_divide_tokens;
  localparam int CH = 4;
  localparam int DW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  divide_tokens_if #(.CHANNELS(CH), .DIV_W(DW)) bus0 ();
  divide_tokens_if #(.CHANNELS(CH), .DIV_W(DW)) bus1 ();

  divide_tokens #(.CHANNELS(CH), .DIV_W(DW), .REG_OUT(0)) dut_comb (
    .clk  (clk),
    .rst_n(rst_n),
    .tok  (bus0.slave)
  );

  divide_tokens #(.CHANNELS(CH), .DIV_W(DW), .REG_OUT(1)) dut_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .tok  (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tokens dropped on each lane since its last pass/restart.
  int          dropped [CH];
  logic [CH-1:0] prev_pass;

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) dropped[i] = 0;
    prev_pass = '0;
  endtask

  task automatic drive(input logic clr, input logic [DW-1:0] d, input logic [CH-1:0] av);
    bus0.clear = clr; bus0.div = d; bus0.a = av;
    bus1.clear = clr; bus1.div = d; bus1.a = av;
  endtask

  // One cycle: drive, check both outputs, then advance the model past the coming edge.
  task automatic step(input logic clr, input logic [DW-1:0] d, input logic [CH-1:0] av,
                      output logic [CH-1:0] b0_obs);
    int            ratio;
    logic [CH-1:0] exp;
    @(negedge clk);
    drive(clr, d, av);
    #1;
    ratio = (d == 0) ? 1 : int'(d);
    exp = '0;
    for (int i = 0; i < CH; i++)
      exp[i] = av[i] && !clr && (dropped[i] + 1 >= ratio);
    check("comb_b", bus0.b, exp);
    check("reg_b", bus1.b, prev_pass);
    b0_obs    = bus0.b;
    prev_pass = exp;
    for (int i = 0; i < CH; i++) begin
      if (clr) dropped[i] = 0;
      else if (av[i]) dropped[i] = exp[i] ? 0 : dropped[i] + 1;
    end
  endtask

  initial begin
    logic [CH-1:0] obs;
    logic [15:0]   halve_a;
    logic [15:0]   halve_b;
    logic [3:0]    pt_a;
    logic          rclr;
    logic [DW-1:0] rdiv;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_comb", bus0.b, '0);
    check("reset_reg", bus1.b, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Halving on lane 0 with literal expected sequence.
    halve_a = 16'b1100111010001111;
    halve_b = 16'b0100010010000101;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 4'd2, {3'b000, halve_a[15-k]}, obs);
      check("halve_lit", obs, {3'b000, halve_b[15-k]});
    end
    step(1'b0, 4'd2, 4'b0000, obs);

    // Ratio 3 with a continuous token stream.
    step(1'b1, 4'd3, 4'b0000, obs);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 4'd3, 4'b0001, obs);
      check("div3_lit", obs, {3'b000, (k % 3 == 2)});
    end

    // div=0 and div=1 both pass every token.
    pt_a = 4'b1011;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b0, DW'(m), {3'b000, pt_a[3-k]}, obs);
        check("passthru_lit", obs, {3'b000, pt_a[3-k]});
      end
    end

    // Ratio lowered below the current count.
    step(1'b1, 4'd4, 4'b0000, obs);
    step(1'b0, 4'd4, 4'b0001, obs);
    step(1'b0, 4'd4, 4'b0001, obs);
    step(1'b0, 4'd2, 4'b0001, obs);
    check("lower_pass", obs, 4'b0001);
    step(1'b0, 4'd2, 4'b0001, obs);
    check("lower_drop", obs, 4'b0000);
    step(1'b0, 4'd2, 4'b0001, obs);
    check("lower_pass2", obs, 4'b0001);

    // Clear drops tokens and restarts lanes independently.
    step(1'b1, 4'd2, 4'b0000, obs);
    step(1'b0, 4'd2, 4'b0001, obs);
    step(1'b1, 4'd2, 4'b0011, obs);
    check("clear_drop", obs, 4'b0000);
    step(1'b0, 4'd2, 4'b0011, obs);
    check("after_clear1", obs, 4'b0000);
    step(1'b0, 4'd2, 4'b0011, obs);
    check("after_clear2", obs, 4'b0011);

    // Async reset mid-stream on lane 2.
    step(1'b1, 4'd3, 4'b0000, obs);
    step(1'b0, 4'd3, 4'b0100, obs);
    step(1'b0, 4'd3, 4'b0100, obs);
    @(negedge clk);
    drive(1'b0, 4'd1, 4'b1111);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_comb", bus0.b, '0);
    check("arst_reg", bus1.b, '0);
    model_reset();
    @(posedge clk);
    #1;
    check("arst_hold_comb", bus0.b, '0);
    check("arst_hold_reg", bus1.b, '0);
    @(negedge clk);
    drive(1'b0, 4'd3, 4'b0000);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd3, 4'b0100, obs);
      check("post_rst_lit", obs, (k == 2) ? 4'b0100 : 4'b0000);
    end

    // Randomized traffic with occasional ratio changes and clears.
    rdiv = 4'd2;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) rdiv = DW'($urandom_range(0, 15));
      rclr = ($urandom_range(0, 24) == 0);
      step(rclr, rdiv, CH'($urandom), obs);
    end
    step(1'b0, rdiv, 4'b0000, obs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
